// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use/HI-LO stalls, ID operand forwarding, mult/div sequencing, stall counter
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 12,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_id_md_start,
  input  logic             i_id_md_is_div,
  input  logic             i_id_hilo_read,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_rf_en,
  input  logic             i_ex_load,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_mem_rf_en,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_rf_en,
  output logic             o_stall_pc,
  output logic             o_stall_ifid,
  output logic             o_bubble_idex,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_md_go,
  output logic             o_md_busy,
  output logic             o_hilo_we,
  output logic [CNT_W-1:0] o_stall_count
);
  localparam int MAXC = DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_hilo_we;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_ex_ok, w_mem_ok, w_wb_ok, w_lu, w_mh, w_stall, w_busy, w_go;
  // a load in EX is never a forwarding source; the load-use stall covers it
  assign w_ex_ok  = i_ex_rf_en && i_ex_rd != 5'd0 && !i_ex_load;
  assign w_mem_ok = i_mem_rf_en && i_mem_rd != 5'd0;
  assign w_wb_ok  = i_wb_rf_en && i_wb_rd != 5'd0;
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] src,
      input logic [4:0] ex_rd, mem_rd, wb_rd, input logic ex_ok, mem_ok, wb_ok);
    return !uses ? 2'b00 :
           (ex_ok && ex_rd == src) ? 2'b01 :
           (mem_ok && mem_rd == src) ? 2'b10 :
           (wb_ok && wb_rd == src) ? 2'b11 : 2'b00;
  endfunction
  assign o_fwd_a_sel = fwd_sel(i_id_uses_rs, i_id_rs, i_ex_rd, i_mem_rd, i_wb_rd, w_ex_ok, w_mem_ok, w_wb_ok);
  assign o_fwd_b_sel = fwd_sel(i_id_uses_rt, i_id_rt, i_ex_rd, i_mem_rd, i_wb_rd, w_ex_ok, w_mem_ok, w_wb_ok);
  assign w_lu = i_ex_load && i_ex_rf_en && i_ex_rd != 5'd0 &&
                ((i_id_uses_rs && i_id_rs == i_ex_rd) || (i_id_uses_rt && i_id_rt == i_ex_rd));
  assign w_busy  = r_state == BUSY && !r_hilo_we;
  assign w_mh    = w_busy && (i_id_md_start || i_id_hilo_read);
  assign w_stall = w_lu || w_mh;
  assign w_go    = i_id_md_start && !w_stall;
  assign o_stall_pc    = w_stall;
  assign o_stall_ifid  = w_stall;
  assign o_bubble_idex = w_stall;
  assign o_md_go       = w_go;
  assign o_md_busy     = w_busy;
  assign o_hilo_we     = r_hilo_we;
  assign o_stall_count = r_stall_cnt;
  // the hilo_we cycle doubles as an idle slot so a waiting mult/div can issue back-to-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hilo_we   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_hilo_we <= 1'b0;
      if (w_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (r_state == IDLE || r_hilo_we) begin
        r_state <= w_go ? BUSY : IDLE;
        if (w_go) r_cnt <= i_id_md_is_div ? DIV_LD : MUL_LD;
      end else if (r_cnt > CW'(1)) begin
        r_cnt <= r_cnt - CW'(1);
      end else begin
        r_hilo_we <= 1'b1;
        r_cnt     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scenarios plus randomized traffic against a cycle-indexed reference model
module tb_hazard_stall_ctrl;
  localparam int MC = 4, DC = 12, CW = 5, CMAX = 31;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic uses_rs, uses_rt, md_start, md_is_div, hilo_read, ex_rf_en, ex_load, mem_rf_en, wb_rf_en;
  logic o_stall_pc, o_stall_ifid, o_bubble_idex, o_md_go, o_md_busy, o_hilo_we;
  logic [1:0] o_fwd_a_sel, o_fwd_b_sel;
  logic [CW-1:0] o_stall_count;
  int checks = 0, errors = 0;

  hazard_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs),
    .i_id_uses_rt(uses_rt), .i_id_md_start(md_start), .i_id_md_is_div(md_is_div),
    .i_id_hilo_read(hilo_read), .i_ex_rd(ex_rd), .i_ex_rf_en(ex_rf_en), .i_ex_load(ex_load),
    .i_mem_rd(mem_rd), .i_mem_rf_en(mem_rf_en), .i_wb_rd(wb_rd), .i_wb_rf_en(wb_rf_en),
    .o_stall_pc(o_stall_pc), .o_stall_ifid(o_stall_ifid), .o_bubble_idex(o_bubble_idex),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel), .o_md_go(o_md_go),
    .o_md_busy(o_md_busy), .o_hilo_we(o_hilo_we), .o_stall_count(o_stall_count));

  always #5 clk = ~clk;

  // reference model: an operation issued in cycle c writes HI/LO in cycle c+N
  int cyc = 0, hilo_cyc = 0, m_cnt = 0;
  bit inflight = 1'b0;
  logic m_lu, m_busy, m_hwe, m_stall, m_go;
  logic [1:0] m_fa, m_fb;
  logic [4:0] st_rd [3];
  logic st_en [3];
  always_comb begin
    st_rd[0] = ex_rd; st_rd[1] = mem_rd; st_rd[2] = wb_rd;
    st_en[0] = ex_rf_en && !ex_load; st_en[1] = mem_rf_en; st_en[2] = wb_rf_en;
    m_fa = 2'b00;
    m_fb = 2'b00;
    for (int s = 2; s >= 0; s--) begin
      if (uses_rs && st_en[s] && st_rd[s] != 0 && st_rd[s] == id_rs) m_fa = 2'(s + 1);
      if (uses_rt && st_en[s] && st_rd[s] != 0 && st_rd[s] == id_rt) m_fb = 2'(s + 1);
    end
    m_lu = ex_load && ex_rf_en && ex_rd != 0 && ((uses_rs && id_rs == ex_rd) || (uses_rt && id_rt == ex_rd));
    m_busy = inflight && cyc < hilo_cyc;
    m_hwe = inflight && cyc == hilo_cyc;
    m_stall = m_lu || (m_busy && (md_start || hilo_read));
    m_go = md_start && !m_stall;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      m_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_stall) m_cnt <= (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      if (m_go) begin
        inflight <= 1'b1;
        hilo_cyc <= cyc + (md_is_div ? DC : MC);
      end else if (m_hwe) inflight <= 1'b0;
    end
  end

  logic [14:0] dut_v, exp_v;
  assign dut_v = {o_stall_pc, o_stall_ifid, o_bubble_idex, o_fwd_a_sel, o_fwd_b_sel, o_md_go, o_md_busy, o_hilo_we, o_stall_count};
  assign exp_v = {m_stall, m_stall, m_stall, m_fa, m_fb, m_go, m_busy, m_hwe, 5'(m_cnt)};

  task automatic clear_in();
    {id_rs, id_rt, ex_rd, mem_rd, wb_rd} = '0;
    {uses_rs, uses_rt, md_start, md_is_div, hilo_read, ex_rf_en, ex_load, mem_rf_en, wb_rf_en} = '0;
  endtask

  task automatic do_reset();
    clear_in();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_in();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (dut_v !== 15'd0) begin errors++; $display("FAIL reset_outputs: got %h want 0000", dut_v); end
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL reset_model: got %h want %h", dut_v, exp_v); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    ex_load = 1; ex_rf_en = 1; ex_rd = 5; id_rs = 5; uses_rs = 1;
    #1;
    checks++;
    if ({o_stall_pc, o_stall_ifid, o_bubble_idex} !== 3'b111) begin
      errors++; $display("FAIL load_use_stall: got %b want 111", {o_stall_pc, o_stall_ifid, o_bubble_idex});
    end
    checks++;
    if (dut_v !== exp_v) begin errors++; $display("FAIL load_use_model: got %h want %h", dut_v, exp_v); end
    @(negedge clk);
    ex_load = 0; ex_rf_en = 0; ex_rd = 0; mem_rd = 5; mem_rf_en = 1;
    #1;
    checks++;
    if (o_stall_pc !== 1'b0 || o_fwd_a_sel !== 2'b10 || o_stall_count !== 5'd1) begin
      errors++; $display("FAIL load_use_fwd: stall=%b fwd_a=%b cnt=%0d want 0 10 1", o_stall_pc, o_fwd_a_sel, o_stall_count);
    end
    @(negedge clk);
  endtask

  task automatic test_forward();
    logic [2:0] en_tab [5] = '{3'b111, 3'b011, 3'b001, 3'b111, 3'b110};
    logic [1:0] want   [5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    do_reset();
    uses_rt = 1; id_rt = 7; ex_rd = 7; mem_rd = 7; wb_rd = 7;
    for (int i = 0; i < 5; i++) begin
      {ex_rf_en, mem_rf_en, wb_rf_en} = en_tab[i];
      if (i == 3) begin id_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0; end
      if (i == 4) begin id_rt = 7; ex_rd = 7; mem_rd = 7; wb_rd = 7; end
      #1;
      checks++;
      if (o_fwd_b_sel !== want[i] || o_stall_pc !== 1'b0) begin
        errors++; $display("FAIL forward_%0d: fwd_b=%b stall=%b want %b 0", i, o_fwd_b_sel, o_stall_pc, want[i]);
      end
      @(negedge clk);
    end
    uses_rt = 0;
    #1;
    checks++;
    if (o_fwd_b_sel !== 2'b00) begin errors++; $display("FAIL forward_unused: got %b want 00", o_fwd_b_sel); end
    @(negedge clk);
  endtask

  // issues a mult and holds an mfhi behind it; expects a freshly reset stall counter
  task automatic test_mult(input string tag);
    md_start = 1; md_is_div = 0;
    #1;
    checks++;
    if (o_md_go !== 1'b1 || o_md_busy !== 1'b0) begin
      errors++; $display("FAIL %s_issue: go=%b busy=%b want 1 0", tag, o_md_go, o_md_busy);
    end
    @(negedge clk);
    md_start = 0; hilo_read = 1;
    for (int k = 1; k <= MC; k++) begin
      #1;
      checks++;
      if (o_stall_pc !== (k < MC) || o_hilo_we !== (k == MC) || o_stall_count !== 5'(k - 1)) begin
        errors++;
        $display("FAIL %s_k%0d: stall=%b hilo_we=%b cnt=%0d want %b %b %0d", tag, k, o_stall_pc, o_hilo_we,
                 o_stall_count, k < MC, k == MC, k - 1);
      end
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL %s_model_k%0d: got %h want %h", tag, k, dut_v, exp_v); end
      @(negedge clk);
    end
    hilo_read = 0;
    #1;
    checks++;
    if (o_md_busy !== 1'b0 || o_hilo_we !== 1'b0) begin
      errors++; $display("FAIL %s_done: busy=%b hilo_we=%b want 0 0", tag, o_md_busy, o_hilo_we);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    md_start = 1; md_is_div = 1;
    #1;
    checks++;
    if (o_md_go !== 1'b1) begin errors++; $display("FAIL b2b_issue: go=%b want 1", o_md_go); end
    @(negedge clk);
    for (int k = 1; k <= 2 * DC; k++) begin
      md_start = (k <= DC);
      #1;
      checks++;
      if (o_stall_pc !== (k < DC) || o_md_go !== (k == DC) || o_hilo_we !== (k == DC || k == 2 * DC)) begin
        errors++;
        $display("FAIL b2b_k%0d: stall=%b go=%b hilo_we=%b want %b %b %b", k, o_stall_pc, o_md_go, o_hilo_we,
                 k < DC, k == DC, k == DC || k == 2 * DC);
      end
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL b2b_model_k%0d: got %h want %h", k, dut_v, exp_v); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    md_start = 1; md_is_div = 1;
    @(negedge clk);
    clear_in();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (dut_v !== 15'd0) begin errors++; $display("FAIL midreset_out_%0d: got %h want 0000", k, dut_v); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int k = 0; k < DC + 2; k++) begin
      #1;
      checks++;
      if (o_hilo_we !== 1'b0 || o_md_busy !== 1'b0) begin
        errors++; $display("FAIL midreset_idle_%0d: hilo_we=%b busy=%b want 0 0", k, o_hilo_we, o_md_busy);
      end
      @(negedge clk);
    end
    test_mult("post_reset_mult");
  endtask

  task automatic test_combined();
    do_reset();
    md_start = 1; md_is_div = 0;
    @(negedge clk);
    md_start = 0; hilo_read = 1;
    ex_load = 1; ex_rf_en = 1; ex_rd = 9; id_rt = 9; uses_rt = 1;
    for (int k = 1; k <= MC; k++) begin
      #1;
      checks++;
      if (o_stall_pc !== 1'b1 || o_stall_count !== 5'(k - 1)) begin
        errors++; $display("FAIL combined_k%0d: stall=%b cnt=%0d want 1 %0d", k, o_stall_pc, o_stall_count, k - 1);
      end
      @(negedge clk);
    end
    clear_in();
  endtask

  task automatic test_saturate();
    do_reset();
    ex_load = 1; ex_rf_en = 1; ex_rd = 3; id_rs = 3; uses_rs = 1;
    repeat (CMAX + 8) @(negedge clk);
    #1;
    checks++;
    if (o_stall_count !== 5'(CMAX)) begin errors++; $display("FAIL saturate: got %0d want %0d", o_stall_count, CMAX); end
    @(negedge clk);
    clear_in();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
      {uses_rs, uses_rt, ex_rf_en, ex_load, mem_rf_en, wb_rf_en, md_is_div} = 7'($urandom);
      md_start = ($urandom_range(0, 3) == 0);
      hilo_read = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (dut_v !== exp_v) begin errors++; $display("FAIL random_%0d: got %h want %h", n, dut_v, exp_v); end
      @(negedge clk);
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_forward();
    do_reset();
    test_mult("mult");
    test_back_to_back();
    test_reset_mid();
    test_combined();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
